// File: rtl/cceip_outbound.sv
// rtl/cceip_outbound.sv - CCEIP result stage: strobe masking, forwarding FIFO, byte count and buffer-limit check.
// Optional macro CCEIP_OUTBOUND_TUSER_FILTER_EN drops tuser[0] marker beats from the forwarded stream.
module cceip_outbound #(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_SIZE_WIDTH = 64,
    parameter int C_FIFO_DEPTH = 4
) (
    input  logic                      ap_clk,
    input  logic                      areset,
    input  logic                      outbound_start,
    input  logic [C_SIZE_WIDTH-1:0]   output_buffer_size,
    input  logic                      cceip_s_axis_tvalid,
    output logic                      cceip_s_axis_tready,
    input  logic [C_DATA_WIDTH-1:0]   cceip_s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0] cceip_s_axis_tstrb,
    input  logic [7:0]                cceip_s_axis_tuser,
    input  logic                      cceip_s_axis_tlast,
    output logic                      mm_m_axis_tvalid,
    input  logic                      mm_m_axis_tready,
    output logic [C_DATA_WIDTH-1:0]   mm_m_axis_tdata,
    output logic                      mm_m_axis_tlast,
    output logic [C_SIZE_WIDTH-1:0]   output_data_size,
    output logic                      outbound_done,
    output logic                      overflow
);
    localparam int SW = C_DATA_WIDTH / 8;
    localparam int AW = $clog2(C_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state;
    logic                    start_q;
    logic [C_SIZE_WIDTH-1:0] limit;
    logic [C_DATA_WIDTH-1:0] mem_data [C_FIFO_DEPTH];
    logic                    mem_last [C_FIFO_DEPTH];
    logic [AW:0]             wr_ptr, rd_ptr, count, cnt_after;
    logic [AW-1:0]           last_idx;
    logic                    empty, full, start_edge, accept, rd_fire;
    logic                    is_marker, fits, data_wr, drop, mark_last, push_zero, wr_en;
    logic [C_SIZE_WIDTH:0]   sum;
    logic [C_DATA_WIDTH-1:0] masked, wr_data;
    logic                    wr_last;
    logic                    unused_tuser;

    function automatic logic [C_SIZE_WIDTH:0] popcnt(input logic [SW-1:0] s);
        popcnt = '0;
        for (int i = 0; i < SW; i++) popcnt = popcnt + (C_SIZE_WIDTH+1)'(s[i]);
    endfunction

    always_comb begin
        masked = '0;
        for (int i = 0; i < SW; i++)
            masked[i*8 +: 8] = cceip_s_axis_tstrb[i] ? cceip_s_axis_tdata[i*8 +: 8] : 8'h00;
    end

    assign unused_tuser = ^cceip_s_axis_tuser;
`ifdef CCEIP_OUTBOUND_TUSER_FILTER_EN
    assign is_marker = cceip_s_axis_tuser[0];
`else
    assign is_marker = 1'b0;
`endif

    assign count      = wr_ptr - rd_ptr;
    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(C_FIFO_DEPTH));
    assign start_edge = outbound_start & ~start_q;
    // A full FIFO can still take a beat when the writer drains one in the same cycle.
    assign cceip_s_axis_tready = (state == RUN) & (~full | mm_m_axis_tready);
    assign accept     = cceip_s_axis_tvalid & cceip_s_axis_tready;
    assign rd_fire    = mm_m_axis_tvalid & mm_m_axis_tready;
    assign cnt_after  = count - (AW+1)'(rd_fire);
    assign last_idx   = wr_ptr[AW-1:0] - AW'(1);

    assign sum       = {1'b0, output_data_size} + popcnt(cceip_s_axis_tstrb);
    assign fits      = ~overflow & (sum <= {1'b0, limit});
    assign data_wr   = accept & ~is_marker & fits;
    assign drop      = accept & ~is_marker & ~fits;
    // A marker tlast retags the newest entry if it is still queued, otherwise it needs an empty carrier beat.
    assign mark_last = accept & is_marker & cceip_s_axis_tlast & ~overflow & (cnt_after != '0);
    assign push_zero = accept & is_marker & cceip_s_axis_tlast & ~overflow & (cnt_after == '0);
    assign wr_en     = data_wr | push_zero;
    assign wr_data   = data_wr ? masked : '0;
    assign wr_last   = data_wr ? cceip_s_axis_tlast : 1'b1;

    assign mm_m_axis_tvalid = ~empty;
    assign mm_m_axis_tdata  = empty ? '0 : mem_data[rd_ptr[AW-1:0]];
    assign mm_m_axis_tlast  = ~empty & mem_last[rd_ptr[AW-1:0]];

    always_ff @(posedge ap_clk) begin
        if (wr_en) begin
            mem_data[wr_ptr[AW-1:0]] <= wr_data;
            mem_last[wr_ptr[AW-1:0]] <= wr_last;
        end
        if (mark_last) mem_last[last_idx] <= 1'b1;
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state            <= IDLE;
            start_q          <= 1'b0;
            limit            <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            output_data_size <= '0;
            outbound_done    <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            start_q <= outbound_start;
            if (wr_en)   wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_fire) rd_ptr <= rd_ptr + (AW+1)'(1);
            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        limit            <= output_buffer_size;
                        output_data_size <= '0;
                        overflow         <= 1'b0;
                        outbound_done    <= 1'b0;
                        state            <= RUN;
                    end
                end
                RUN: begin
                    if (data_wr) output_data_size <= sum[C_SIZE_WIDTH-1:0];
                    if (drop) overflow <= 1'b1;
                    if (accept && cceip_s_axis_tlast) state <= DRAIN;
                end
                DRAIN: begin
                    if (empty) begin
                        outbound_done <= 1'b1;
                        state         <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cceip_outbound.sv
// tb/tb_cceip_outbound.sv - Directed table-driven bench for cceip_outbound.
module tb_cceip_outbound;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] obs;
    logic        s_tvalid, s_tready, s_tlast;
    logic [63:0] s_tdata;
    logic [7:0]  s_tstrb, s_tuser;
    logic        m_tvalid, m_tready, m_tlast;
    logic [63:0] m_tdata;
    logic [63:0] size;
    logic        done, ovf;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    logic [63:0] got_data[$];
    bit          got_last[$];
    int          in_cyc[$];
    int          out_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cceip_outbound dut (
        .ap_clk(clk), .areset(rst), .outbound_start(start), .output_buffer_size(obs),
        .cceip_s_axis_tvalid(s_tvalid), .cceip_s_axis_tready(s_tready),
        .cceip_s_axis_tdata(s_tdata), .cceip_s_axis_tstrb(s_tstrb),
        .cceip_s_axis_tuser(s_tuser), .cceip_s_axis_tlast(s_tlast),
        .mm_m_axis_tvalid(m_tvalid), .mm_m_axis_tready(m_tready),
        .mm_m_axis_tdata(m_tdata), .mm_m_axis_tlast(m_tlast),
        .output_data_size(size), .outbound_done(done), .overflow(ovf)
    );

    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            got_data.push_back(m_tdata);
            got_last.push_back(m_tlast);
            out_cyc.push_back(cyc);
        end
        if (s_tvalid && s_tready) in_cyc.push_back(cyc);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        got_data.delete(); got_last.delete(); in_cyc.delete(); out_cyc.delete();
    endtask

    task automatic start_frame(input logic [63:0] lim);
        obs = lim; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] strb, input logic [63:0] data,
                             input logic last, input logic [7:0] user);
        int n = 0;
        s_tvalid = 1'b1; s_tstrb = strb; s_tdata = data; s_tlast = last; s_tuser = user;
        #1;
        while (!s_tready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("send_timeout", 64'd1, 64'd0);
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 8'h00;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check("done", done, 1'b1);
    endtask

    typedef struct {
        logic [63:0] limit;
        logic [7:0]  strb;
        logic [63:0] data;
        logic        fwd;
        logic [63:0] exp_data;
        logic [63:0] exp_size;
        logic        exp_ovf;
    } vec_t;
    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, elapsed %0t", $time);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{64'd100, 8'h07, 64'h1122334455667788, 1'b1, 64'h0000000000667788, 64'd3, 1'b0};
        vecs[1] = '{64'd8,   8'hFF, 64'hA5A5A5A5A5A5A5A5, 1'b1, 64'hA5A5A5A5A5A5A5A5, 64'd8, 1'b0};
        vecs[2] = '{64'd7,   8'hFF, 64'h1111111111111111, 1'b0, 64'h0, 64'd0, 1'b1};
        vecs[3] = '{64'd0,   8'h00, 64'hDEADBEEFDEADBEEF, 1'b1, 64'h0, 64'd0, 1'b0};
        vecs[4] = '{64'd0,   8'h01, 64'h2222222222222222, 1'b0, 64'h0, 64'd0, 1'b1};
        vecs[5] = '{64'd64,  8'h0F, 64'h0123456789ABCDEF, 1'b1, 64'h0000000089ABCDEF, 64'd4, 1'b0};
        vecs[6] = '{64'hFFFFFFFFFFFFFFFF, 8'h3F, 64'hFEDCBA9876543210, 1'b1, 64'h0000BA9876543210, 64'd6, 1'b0};

        rst = 1'b1; start = 1'b0; obs = '0; s_tvalid = 1'b0; s_tdata = '0;
        s_tstrb = '0; s_tuser = '0; s_tlast = 1'b0; m_tready = 1'b1;
        tick(); tick();
        check("rst_s_tready", s_tready, 1'b0);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_m_tdata", m_tdata, 64'h0);
        check("rst_size", size, 64'h0);
        check("rst_done", done, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        tick();

        // 8 full beats, limit 64, latency 1 cycle each
        clear_mon();
        start_frame(64'd64);
        for (int i = 0; i < 8; i++)
            send_beat(8'hFF, 64'h0101010101010101 * (i + 1), i == 7, 8'h00);
        wait_done();
        check("f1_size", size, 64'd64);
        check("f1_ovf", ovf, 1'b0);
        check("f1_count", got_data.size(), 64'd8);
        for (int i = 0; i < 8 && i < got_data.size(); i++) begin
            check($sformatf("f1_data%0d", i), got_data[i], 64'h0101010101010101 * (i + 1));
            check($sformatf("f1_last%0d", i), got_last[i], i == 7);
            if (i < in_cyc.size() && i < out_cyc.size())
                check($sformatf("f1_lat%0d", i), out_cyc[i] - in_cyc[i], 64'd1);
        end

        // limit 20: 8 + 8 fit, the 5-byte third beat would reach 21 and is dropped
        clear_mon();
        start_frame(64'd20);
        send_beat(8'hFF, 64'h3333333333333333, 1'b0, 8'h00);
        send_beat(8'hFF, 64'h4444444444444444, 1'b0, 8'h00);
        send_beat(8'h1F, 64'h5555555555555555, 1'b1, 8'h00);
        wait_done();
        check("f2_size", size, 64'd16);
        check("f2_ovf", ovf, 1'b1);
        check("f2_count", got_data.size(), 64'd2);
        for (int i = 0; i < got_data.size(); i++)
            check($sformatf("f2_last%0d", i), got_last[i], 1'b0);

        // single-beat frames from the table
        for (int v = 0; v < 7; v++) begin
            clear_mon();
            start_frame(vecs[v].limit);
            check($sformatf("v%0d_size_clr", v), size, 64'd0);
            send_beat(vecs[v].strb, vecs[v].data, 1'b1, 8'h00);
            check($sformatf("v%0d_m_tvalid", v), m_tvalid, vecs[v].fwd);
            if (vecs[v].fwd) begin
                check($sformatf("v%0d_m_tdata", v), m_tdata, vecs[v].exp_data);
                check($sformatf("v%0d_m_tlast", v), m_tlast, 1'b1);
            end
            wait_done();
            check($sformatf("v%0d_size", v), size, vecs[v].exp_size);
            check($sformatf("v%0d_ovf", v), ovf, vecs[v].exp_ovf);
            check($sformatf("v%0d_count", v), got_data.size(), {63'd0, vecs[v].fwd});
        end

        // backpressure: 4 beats fill the FIFO, beat 5 waits
        clear_mon();
        m_tready = 1'b0;
        start_frame(64'd1000);
        for (int i = 0; i < 4; i++)
            send_beat(8'hFF, 64'h1000 + i, 1'b0, 8'h00);
        s_tvalid = 1'b1; s_tstrb = 8'hFF; s_tdata = 64'h1004;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_s_tready", s_tready, 1'b0);
            check("bp_m_tdata", m_tdata, 64'h1000);
            tick();
        end
        check("bp_accepted", in_cyc.size(), 64'd4);
        m_tready = 1'b1;
        send_beat(8'hFF, 64'h1004, 1'b0, 8'h00);
        send_beat(8'hFF, 64'h1005, 1'b1, 8'h00);
        wait_done();
        check("bp_count", got_data.size(), 64'd6);
        for (int i = 0; i < 6 && i < got_data.size(); i++) begin
            check($sformatf("bp_data%0d", i), got_data[i], 64'h1000 + i);
            check($sformatf("bp_last%0d", i), got_last[i], i == 5);
        end
        check("bp_size", size, 64'd48);

        // reset in RUN with 2 beats buffered
        m_tready = 1'b0;
        start_frame(64'd1000);
        send_beat(8'hFF, 64'hAAAA, 1'b0, 8'h00);
        send_beat(8'hFF, 64'hBBBB, 1'b0, 8'h00);
        check("pre_rst_size", size, 64'd16);
        rst = 1'b1;
        tick();
        check("mid_rst_s_tready", s_tready, 1'b0);
        check("mid_rst_m_tvalid", m_tvalid, 1'b0);
        check("mid_rst_m_tlast", m_tlast, 1'b0);
        check("mid_rst_m_tdata", m_tdata, 64'h0);
        check("mid_rst_size", size, 64'h0);
        check("mid_rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        m_tready = 1'b1;
        tick();
        clear_mon();
        start_frame(64'd1000);
        send_beat(8'hFF, 64'hCCCC, 1'b1, 8'h00);
        wait_done();
        check("post_rst_size", size, 64'd8);
        check("post_rst_count", got_data.size(), 64'd1);
        if (got_data.size() > 0) check("post_rst_data", got_data[0], 64'hCCCC);

`ifdef CCEIP_OUTBOUND_TUSER_FILTER_EN
        clear_mon();
        m_tready = 1'b0;
        start_frame(64'd1000);
        send_beat(8'hFF, 64'h0F0F, 1'b0, 8'h01);
        send_beat(8'hFF, 64'h0A0A, 1'b0, 8'h00);
        send_beat(8'hFF, 64'h0B0B, 1'b0, 8'h00);
        send_beat(8'hFF, 64'h0C0C, 1'b1, 8'h01);
        m_tready = 1'b1;
        wait_done();
        check("flt_count", got_data.size(), 64'd2);
        for (int i = 0; i < 2 && i < got_data.size(); i++)
            check($sformatf("flt_last%0d", i), got_last[i], i == 1);
        if (got_data.size() > 1) check("flt_data1", got_data[1], 64'h0B0B);
        check("flt_size", size, 64'd16);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
